// File: rtl/ask_pkg.sv
// Shared types and default parameters for the ASK demodulator.
package ask_pkg;

  // Demodulator lock state.
  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_e;

  // Default configuration: 8 MHz sample clock, 10 kbps symbols.
  localparam int SPB_DEF       = 800;  // samples per bit, even and >= 8
  localparam int ENV_LOG2_DEF  = 4;    // moving-average window = 16 samples
  localparam int TH_HI_DEF     = 20;   // envelope at/above this -> level 1
  localparam int TH_LO_DEF     = 12;   // envelope at/below this -> level 0
  localparam int LOSS_BITS_DEF = 8;    // consecutive 0 bits that drop lock

  // Rectified sample width; input samples are MAG_W+1 bits signed.
  localparam int MAG_W = 6;

  // |x| clipped to MAG_W bits: the single most-negative code has no
  // positive counterpart and saturates to full scale.
  function automatic logic [MAG_W-1:0] abs_sat(input logic signed [MAG_W:0] x);
    logic signed [MAG_W:0] neg;
    neg = -x;
    if (!x[MAG_W]) return x[MAG_W-1:0];
    if (x == {1'b1, {MAG_W{1'b0}}}) return '1;
    return neg[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/ask_env_det.sv
// Envelope detector: registered rectifier followed by a moving-sum
// filter over the last 2^ENV_LOG2 magnitudes.
module ask_env_det
  import ask_pkg::*;
#(
  parameter int ENV_LOG2 = ENV_LOG2_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [MAG_W:0]   din_i,
  output logic [MAG_W-1:0]        envelope_o
);

  localparam int DEPTH = 1 << ENV_LOG2;
  localparam int ACC_W = MAG_W + ENV_LOG2;

  logic [MAG_W-1:0] mag_q;
  logic [MAG_W-1:0] dly_q [DEPTH];
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  // The sum always contains the sample being dropped, so it cannot
  // underflow, and DEPTH full-scale samples fit exactly in ACC_W bits.
  assign acc_d = acc_q + ACC_W'(mag_q) - ACC_W'(dly_q[DEPTH-1]);

  // Rectify, shift the delay line and update the running sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_q <= '0;
      acc_q <= '0;
      // NOTE: the delay line is reset together with acc_q; leaving it
      // unreset would subtract stale garbage from a freshly cleared sum.
      for (int i = 0; i < DEPTH; i++) dly_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage read the previous
      // cycle's value, which is what makes this a true shift register.
      mag_q    <= abs_sat(din_i);
      dly_q[0] <= mag_q;
      for (int i = 1; i < DEPTH; i++) dly_q[i] <= dly_q[i-1];
      acc_q    <= acc_d;
    end
  end

  assign envelope_o = acc_q[ACC_W-1:ENV_LOG2];

endmodule

// File: rtl/ask_demod.sv
// Non-coherent ASK demodulator: envelope detection, hysteresis slicer,
// edge-driven bit timing recovery and carrier-lock tracking.
module ask_demod
  import ask_pkg::*;
#(
  parameter int SPB       = SPB_DEF,
  parameter int ENV_LOG2  = ENV_LOG2_DEF,
  parameter int TH_HI     = TH_HI_DEF,
  parameter int TH_LO     = TH_LO_DEF,
  parameter int LOSS_BITS = LOSS_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [MAG_W:0] din,
  output logic                  bit_out,
  output logic                  bit_valid,
  output logic                  carrier_lock,
  output logic [MAG_W-1:0]      envelope
);

  localparam int CNT_W = $clog2(SPB);
  localparam int ZR_W  = $clog2(LOSS_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(SPB / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPB - 1);
  localparam logic [ZR_W-1:0]  ZR_LOSS  = ZR_W'(LOSS_BITS);
  localparam logic [MAG_W-1:0] TH_HI_V  = MAG_W'(TH_HI);
  localparam logic [MAG_W-1:0] TH_LO_V  = MAG_W'(TH_LO);

  logic [MAG_W-1:0] env_w;
  logic             level_q, level_d, level_dly_q;
  logic             edge_w, rise_w;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ZR_W-1:0]  zrun_q, zrun_d;
  logic             bit_q, bit_d;
  logic             valid_q, valid_d;
  logic             lock_q;

  ask_env_det #(
    .ENV_LOG2 (ENV_LOG2)
  ) u_env_det (
    .clk        (clk),
    .rst        (rst),
    .din_i      (din),
    .envelope_o (env_w)
  );

  // Hysteresis slicer: only a clear excursion past a threshold moves level.
  always_comb begin
    // NOTE: defaulting level_d to its held value first keeps this block
    // purely combinational; a missing else path would infer a latch.
    level_d = level_q;
    if (env_w >= TH_HI_V)      level_d = 1'b1;
    else if (env_w <= TH_LO_V) level_d = 1'b0;
  end

  assign edge_w = level_q ^ level_dly_q;
  assign rise_w = level_q & ~level_dly_q;

  // Lock/timing FSM: resync the bit counter on level edges, sample at mid-bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    zrun_d  = zrun_q;
    bit_d   = bit_q;
    valid_d = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (rise_w) begin
          state_d = TRACK;
          cnt_d   = '0;
          zrun_d  = '0;
        end
      end
      TRACK: begin
        if (edge_w) begin
          // Phase resync takes priority over a coincident mid-bit sample.
          cnt_d = '0;
        end else begin
          cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
          if (cnt_q == CNT_MID) begin
            valid_d = 1'b1;
            bit_d   = level_q;
            if (level_q) begin
              zrun_d = '0;
            end else begin
              zrun_d = zrun_q + ZR_W'(1);
              if (zrun_d == ZR_LOSS) state_d = HUNT;
            end
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // Slicer, edge-detect and FSM registers; lock flag trails the state by one
  // cycle so it drops the cycle after the final strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      state_q     <= HUNT;
      cnt_q       <= '0;
      zrun_q      <= '0;
      bit_q       <= 1'b0;
      valid_q     <= 1'b0;
      lock_q      <= 1'b0;
    end else begin
      level_q     <= level_d;
      level_dly_q <= level_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      zrun_q      <= zrun_d;
      bit_q       <= bit_d;
      valid_q     <= valid_d;
      lock_q      <= (state_q == TRACK);
    end
  end

  assign bit_out      = bit_q;
  assign bit_valid    = valid_q;
  assign carrier_lock = lock_q;
  assign envelope     = env_w;

endmodule
